// File: rtl/jt49_bus.sv
// Command FIFO and bus sequencer for a YM2149/AY-3-8910 PSG register port.
// Commands are queued on any clock and played out as timed
// SETUP / STROBE (write) or SETUP / RDWAIT (read) accesses, with each access
// followed by an idle GAP. Every bus-timing step is qualified by cen.
module jt49_bus #(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned WR_LEN  = 2,
  parameter int unsigned GAP_LEN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rd,
  input  logic [3:0]       cmd_addr,
  input  logic [7:0]       cmd_data,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             busy,
  output logic [FIFO_AW:0] level,
  output logic [3:0]       addr,
  output logic [7:0]       din,
  output logic             cs_n,
  output logic             wr_n,
  input  logic [7:0]       psg_dout
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned CW    = 4;

  typedef struct packed {
    logic       rd;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RDWAIT,
    ST_GAP
  } state_t;

  cmd_t               mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      level_q, level_d;
  logic               cmd_ready_q, cmd_ready_d;
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               rd_q, rd_d;
  logic [3:0]         addr_q, addr_d;
  logic [7:0]         din_q, din_d;
  logic               cs_n_q, cs_n_d;
  logic               wr_n_q, wr_n_d;
  logic               busy_q, busy_d;
  logic               rsp_valid_q;
  logic [7:0]         rsp_data_q;
  logic               push, pop, rsp_fire;
  cmd_t               head;
  cmd_t               wr_cmd;

  assign push   = cmd_valid & cmd_ready_q;
  assign wr_cmd = '{rd: cmd_rd, addr: cmd_addr, data: cmd_data};

  // FIFO storage: written on accepted pushes regardless of cen
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_cmd;
  end

  // Next-state logic: FSM sequencing, pop decision, occupancy and bus outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    din_d    = din_q;
    pop      = 1'b0;
    rsp_fire = 1'b0;
    head     = mem_q[rd_ptr_q];
    if (cen) begin
      case (state_q)
        ST_IDLE: begin
          if (level_q != '0) begin
            pop     = 1'b1;
            rd_d    = head.rd;
            addr_d  = head.addr;
            din_d   = head.rd ? 8'h00 : head.data;
            state_d = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (rd_q) begin
            state_d = ST_RDWAIT;
            cnt_d   = CW'(1);
          end else begin
            state_d = ST_STROBE;
            cnt_d   = CW'(WR_LEN - 1);
          end
        end
        ST_STROBE: begin
          if (cnt_q == '0) begin
            state_d = ST_GAP;
            cnt_d   = CW'(GAP_LEN - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_RDWAIT: begin
          if (cnt_q == '0) begin
            rsp_fire = 1'b1;
            state_d  = ST_GAP;
            cnt_d    = CW'(GAP_LEN - 1);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    cmd_ready_d = (level_d != LW'(DEPTH));
    cs_n_d      = !((state_d == ST_STROBE) || (state_d == ST_RDWAIT));
    wr_n_d      = (state_d != ST_STROBE);
    busy_d      = (level_d != '0) || (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cmd_ready_q <= 1'b1;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      level_q     <= level_d;
      cmd_ready_q <= cmd_ready_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_fire;
      if (push)     wr_ptr_q   <= wr_ptr_q + FIFO_AW'(1);
      if (pop)      rd_ptr_q   <= rd_ptr_q + FIFO_AW'(1);
      if (rsp_fire) rsp_data_q <= psg_dout;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign level     = level_q;
  assign busy      = busy_q;
  assign addr      = addr_q;
  assign din       = din_q;
  assign cs_n      = cs_n_q;
  assign wr_n      = wr_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jt49_bus.sv
// Bench for jt49_bus: a queue-based access-timeline model checked every clock,
// plus directed scenarios with hand-computed expectations.
module tb_jt49_bus;

  localparam int FIFO_AW = 2;
  localparam int WR_LEN  = 2;
  localparam int GAP_LEN = 1;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rd = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic [7:0] psg_dout = '0;
  logic       cmd_ready, rsp_valid, busy, cs_n, wr_n;
  logic [7:0] rsp_data, din;
  logic [3:0] addr;
  logic [FIFO_AW:0] level;

  jt49_bus #(.FIFO_AW(FIFO_AW), .WR_LEN(WR_LEN), .GAP_LEN(GAP_LEN)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .level(level),
    .addr(addr), .din(din), .cs_n(cs_n), .wr_n(wr_n), .psg_dout(psg_dout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cen_mode = 0;  // 0: always on, 1: one clk in three, 2: random, 3: held off
  int div = 0;
  bit psg_fix = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: commands wait in a queue; an active access is described only
  // by how many cen ticks have elapsed since it was popped.
  typedef struct {
    bit       rd;
    bit [3:0] a;
    bit [7:0] d;
  } cmd_s;

  cmd_s     q[$];
  cmd_s     cur;
  cmd_s     nc;
  bit       m_act = 1'b0;
  int       m_t = 0;
  bit [3:0] m_addr = '0;
  bit [7:0] m_din = '0;
  bit [7:0] m_rdata = '0;
  bit       m_rv = 1'b0;
  bit       m_full;

  // Tick count (since pop) at which the access has returned to idle
  function automatic int last_t(input bit rd);
    return rd ? 3 + GAP_LEN : 1 + WR_LEN + GAP_LEN;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      m_act = 1'b0; m_t = 0; m_addr = '0; m_din = '0; m_rdata = '0; m_rv = 1'b0;
    end else begin
      m_full = (q.size() == DEPTH);
      m_rv = 1'b0;
      if (cen) begin
        if (m_act) begin
          m_t++;
          if (cur.rd && m_t == 3) begin
            m_rv = 1'b1;
            m_rdata = psg_dout;
          end
          if (m_t == last_t(cur.rd)) m_act = 1'b0;
        end else if (q.size() != 0) begin
          cur = q.pop_front();
          m_act = 1'b1;
          m_t = 0;
          m_addr = cur.a;
          m_din = cur.rd ? 8'h00 : cur.d;
        end
      end
      if (cmd_valid && !m_full) begin
        nc.rd = cmd_rd; nc.a = cmd_addr; nc.d = cmd_data;
        q.push_back(nc);
      end
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst) begin
      chk("cmd_ready", cmd_ready, q.size() < DEPTH);
      chk("level", level, q.size());
      chk("busy", busy, (q.size() != 0) || m_act);
      chk("addr", addr, m_addr);
      chk("din", din, m_din);
      chk("cs_n", cs_n, !(m_act && m_t >= 1 && (cur.rd ? m_t <= 2 : m_t <= WR_LEN)));
      chk("wr_n", wr_n, !(m_act && !cur.rd && m_t >= 1 && m_t <= WR_LEN));
      chk("rsp_valid", rsp_valid, m_rv);
      chk("rsp_data", rsp_data, m_rdata);
    end
  end

  // cen pattern and PSG read-data generator
  initial forever begin
    @(negedge clk);
    case (cen_mode)
      0: cen = 1'b1;
      1: begin cen = (div == 0); div = (div + 1) % 3; end
      2: cen = 1'($urandom % 2);
      default: cen = 1'b0;
    endcase
    if (!psg_fix) psg_dout = 8'($urandom);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic push(input bit rd, input bit [3:0] a, input bit [7:0] d);
    cmd_rd = rd; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || m_act) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_wait", busy, 0);
  endtask

  int cs_lo, wr_lo, rv_n, cs_f, wr_f;
  logic pcs, pwr;
  logic [3:0] paddr;
  int seq[$];

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", level, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_addr", addr, 0);
    chk("rst_din", din, 0);
    chk("rst_rv", rsp_valid, 0);
    chk("rst_rdata", rsp_data, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single write: addr 7, data 0x38
    wait_idle();
    push(1'b0, 4'd7, 8'h38);
    cs_lo = 0; wr_lo = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      if (!cs_n) cs_lo++;
      if (!wr_n) wr_lo++;
      if (i == 1) begin
        chk("w_addr", addr, 7);
        chk("w_din", din, 8'h38);
        chk("w_setup_cs", cs_n, 1);
      end
      if (i == 4) chk("w_busy_gap", busy, 1);
    end
    chk("w_cs_lo", cs_lo, 2);
    chk("w_wr_lo", wr_lo, 2);
    chk("w_idle5", busy, 0);

    // Single read: addr 1, PSG returns 0x0F
    wait_idle();
    psg_fix = 1'b1;
    psg_dout = 8'h0F;
    push(1'b1, 4'd1, 8'hAA);
    cs_lo = 0; wr_lo = 0; rv_n = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (!cs_n) cs_lo++;
      if (!wr_n) wr_lo++;
      if (rsp_valid) rv_n++;
      if (i == 1) chk("r_din", din, 0);
    end
    chk("r_cs_lo", cs_lo, 2);
    chk("r_wr_lo", wr_lo, 0);
    chk("r_pulses", rv_n, 1);
    chk("r_data", rsp_data, 8'h0F);
    psg_fix = 1'b0;

    // Two back-to-back writes to register 13
    wait_idle();
    push(1'b0, 4'd13, 8'h0E);
    push(1'b0, 4'd13, 8'h0E);
    pcs = cs_n; pwr = wr_n; cs_f = 0; wr_f = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (pcs && !cs_n) cs_f++;
      if (pwr && !wr_n) wr_f++;
      pcs = cs_n; pwr = wr_n;
    end
    chk("r13_wr_pulses", wr_f, 2);
    chk("r13_cs_pulses", cs_f, 2);

    // Fill the FIFO while stalled, then drain in order
    wait_idle();
    cen_mode = 3;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      cmd_rd = 1'b0; cmd_addr = 4'(i); cmd_data = 8'(i * 16); cmd_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("stall_level", level, 4);
    chk("stall_ready", cmd_ready, 0);
    chk("stall_cs_n", cs_n, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_hold", level, 4);
    cen_mode = 0;
    paddr = addr;
    seq.delete();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (addr != paddr) seq.push_back(int'(addr));
      paddr = addr;
    end
    chk("order_n", seq.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < seq.size()) chk("order_addr", seq[k], k + 1);

    // cen one clock in three: write phases stretch by 3
    wait_idle();
    cen_mode = 1;
    push(1'b0, 4'd2, 8'h55);
    cs_lo = 0; wr_lo = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!cs_n) cs_lo++;
      if (!wr_n) wr_lo++;
    end
    chk("slow_cs_lo", cs_lo, 3 * WR_LEN);
    chk("slow_wr_lo", wr_lo, 3 * WR_LEN);
    cen_mode = 0;

    // Randomised traffic under random cen, then with cen held high
    wait_idle();
    cen_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom % 3 == 0);
      cmd_rd = 1'($urandom);
      cmd_addr = 4'($urandom);
      cmd_data = 8'($urandom);
    end
    cen_mode = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom % 6 == 0);
      cmd_rd = 1'($urandom);
      cmd_addr = 4'($urandom);
      cmd_data = 8'($urandom);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();

    // Reset during a strobe with three commands queued
    push(1'b0, 4'd9, 8'h11);
    push(1'b0, 4'd10, 8'h22);
    push(1'b0, 4'd11, 8'h33);
    push(1'b0, 4'd12, 8'h44);
    for (int n = 0; n < 20 && !(cs_n == 1'b0 && wr_n == 1'b0); n++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_strobe", wr_n, 0);
    chk("pre_rst_level", level, 3);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_cs_n", cs_n, 1);
    chk("arst_wr_n", wr_n, 1);
    chk("arst_level", level, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    wr_lo = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!wr_n) wr_lo++;
    end
    chk("post_rst_strobes", wr_lo, 0);
    chk("post_rst_level", level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
